// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared constants, types and helpers for the stream demux.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

    // Entries held per output channel
    localparam int CH_DEPTH = 2;

    // Per-channel occupancy, 0..CH_DEPTH
    typedef logic [1:0] cnt_t;

    // Selector width for n channels; a single channel still needs one bit
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : stream_demux_pkg
`default_nettype wire

// File: rtl/demux_chan_buf.sv
`default_nettype none
// ============================================================================
// Module      : demux_chan_buf
// Description : Two-entry per-channel FIFO with valid/ready output side.
//               Full is derived from the registered count only.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_chan_buf
    import stream_demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data
);

    logic [W-1:0] r_mem [CH_DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    cnt_t         r_cnt;
    logic         w_push;
    logic         w_pop;

    assign full   = (r_cnt == cnt_t'(CH_DEPTH));
    assign valid  = (r_cnt != '0);
    assign data   = r_mem[r_rd_ptr];

    // A push into a full buffer is ignored rather than corrupting the head
    assign w_push = push & ~full;
    assign w_pop  = valid & ready;

    // Storage, one-bit wrap pointers (depth is two) and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= '0;
            for (int i = 0; i < CH_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule : demux_chan_buf
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux
// Description : 1-to-N_CH streaming demultiplexer with valid/ready handshake,
//               two-entry buffering per channel and broadcast mode.
//               Out-of-range selectors are accepted, dropped and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int SEL_W = sel_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_bcast,
    output logic [N_CH-1:0]   out_valid,
    input  logic [N_CH-1:0]   out_ready,
    output logic [N_CH*W-1:0] out_data,
    output logic              err_sel
);

    localparam int              c_sel_span = 1 << SEL_W;
    localparam logic [SEL_W:0]  c_n_ch     = (SEL_W + 1)'(N_CH);

    logic [N_CH-1:0]       w_full;
    logic [c_sel_span-1:0] w_full_ext;
    logic                  w_sel_ok;
    logic                  w_all_nonfull;
    logic                  w_fire;
    logic                  w_drop;
    logic [N_CH-1:0]       w_push;
    logic                  r_err_sel;

    assign w_sel_ok      = ({1'b0, in_sel} < c_n_ch);
    assign w_all_nonfull = ~|w_full;

    // Pad the full vector to the selector range so any in_sel indexes safely
    always_comb begin
        w_full_ext             = '0;
        w_full_ext[N_CH-1:0]   = w_full;
    end

    // Readiness uses registered counts only: no path from out_ready
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = w_all_nonfull;
        end else if (w_sel_ok) begin
            in_ready = ~w_full_ext[in_sel];
        end
    end

    assign w_fire = in_valid & in_ready;
    assign w_drop = w_fire & ~in_bcast & ~w_sel_ok;

    // Push-enable fan-out: every channel on broadcast, decoded channel otherwise
    always_comb begin
        w_push = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_push[k] = w_fire &
                        (in_bcast | (w_sel_ok & ({1'b0, in_sel} == (SEL_W + 1)'(k))));
        end
    end

    // One-cycle flag following each dropped out-of-range word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sel <= 1'b0;
        end else begin
            r_err_sel <= w_drop;
        end
    end

    assign err_sel = r_err_sel;

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        demux_chan_buf #(
            .W (W)
        ) u_buf (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (w_push[k]),
            .push_data (in_data),
            .full      (w_full[k]),
            .valid     (out_valid[k]),
            .ready     (out_ready[k]),
            .data      (out_data[k*W +: W])
        );
    end

endmodule : stream_demux
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux
// Description : Self-checking bench for stream_demux against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        rst_n;

    // Four-channel instance
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        err_sel;

    // Three-channel instance for out-of-range selectors
    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic        b_in_bcast;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic [23:0] b_out_data;
    logic        b_err_sel;

    int n_total = 0;
    int n_pass  = 0;

    typedef logic [7:0] q8_t[$];
    q8_t mq [4];

    always #5 clk = ~clk;

    stream_demux #(.N_CH(4), .W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_sel(err_sel)
    );

    stream_demux #(.N_CH(3), .W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_sel(b_in_sel), .in_bcast(b_in_bcast),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .err_sel(b_err_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock of the four-channel instance: compare against the queue model,
    // then advance the model with the same handshakes
    task automatic cycle(output logic fired);
        logic [3:0] ev;
        logic       er;
        logic       v;
        logic       b;
        logic [1:0] s;
        logic [7:0] d;
        logic [3:0] rd;
        #1;
        ev = '0;
        for (int k = 0; k < 4; k++) ev[k] = (mq[k].size() != 0);
        chk("out_valid", 32'(out_valid), 32'(ev));
        for (int k = 0; k < 4; k++)
            if (ev[k]) chk($sformatf("out_data%0d", k), 32'(out_data[k*8 +: 8]), 32'(mq[k][0]));
        if (in_bcast) begin
            er = 1'b1;
            for (int k = 0; k < 4; k++) if (mq[k].size() >= 2) er = 1'b0;
        end else begin
            er = (mq[in_sel].size() < 2);
        end
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("err_sel", 32'(err_sel), 32'd0);
        v = in_valid; b = in_bcast; s = in_sel; d = in_data; rd = out_ready;
        fired = v & er;
        @(posedge clk);
        for (int k = 0; k < 4; k++)
            if (ev[k] && rd[k]) void'(mq[k].pop_front());
        if (fired) begin
            if (b) for (int k = 0; k < 4; k++) mq[k].push_back(d);
            else   mq[s].push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] s, input logic b, input logic [7:0] d, output logic fired);
        in_valid = 1'b1; in_sel = s; in_bcast = b; in_data = d;
        cycle(fired);
    endtask

    logic f;
    int   waited;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1; in_sel = 2'd0; in_bcast = 1'b0; in_data = 8'hFF; out_ready = 4'hF;
        b_in_valid = 1'b0; b_in_sel = 2'd0; b_in_bcast = 1'b0; b_in_data = 8'h00; b_out_ready = 3'b111;

        // Reset held with a word offered
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", out_data, 32'd0);
            chk("rst_err_sel", 32'(err_sel), 32'd0);
            chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #1 chk("post_rst_out_data", out_data, 32'd0);
        cycle(f);

        // Unicast to ch1 then ch3
        send(2'd1, 1'b0, 8'h11, f);
        send(2'd3, 1'b0, 8'h22, f);
        in_valid = 1'b0;
        repeat (2) cycle(f);

        // Backpressure on ch2 while ch0 keeps flowing
        out_ready = 4'b1011;
        send(2'd2, 1'b0, 8'hA0, f);
        send(2'd2, 1'b0, 8'hA1, f);
        send(2'd2, 1'b0, 8'hA2, f);
        chk("ch2_full_blocks", 32'(f), 32'd0);
        send(2'd0, 1'b0, 8'h55, f);
        chk("ch0_not_blocked", 32'(f), 32'd1);
        out_ready = 4'hF;
        waited = 0;
        do begin
            send(2'd2, 1'b0, 8'hA2, f);
            waited++;
        end while (!f && waited < 10);
        chk("ch2_accepts_after_drain", 32'(f), 32'd1);
        in_valid = 1'b0;
        repeat (3) cycle(f);

        // Broadcast blocked by a full ch1, accepted once it drains
        out_ready = 4'b1101;
        send(2'd1, 1'b0, 8'h31, f);
        send(2'd1, 1'b0, 8'h32, f);
        send(2'd0, 1'b1, 8'h7E, f);
        chk("bcast_blocked", 32'(f), 32'd0);
        out_ready = 4'b0010;
        send(2'd0, 1'b1, 8'h7E, f);
        out_ready = 4'b0000;
        waited = 0;
        while (!f && waited < 5) begin
            send(2'd0, 1'b1, 8'h7E, f);
            waited++;
        end
        chk("bcast_accepted", 32'(f), 32'd1);
        in_valid = 1'b0;
        #1 chk("bcast_all_valid", 32'(out_valid), 32'hF);
        cycle(f);
        out_ready = 4'hF;
        repeat (3) cycle(f);

        // Full-rate unicast with every consumer ready
        for (int i = 0; i < 16; i++) begin
            send(2'($urandom_range(0, 3)), 1'b0, 8'($urandom), f);
            chk("tput_accept", 32'(f), 32'd1);
        end
        in_valid = 1'b0;
        cycle(f);

        // Random traffic with random backpressure
        for (int i = 0; i < 64; i++) begin
            logic [1:0] s;
            logic       b;
            logic [7:0] d;
            s = 2'($urandom_range(0, 3));
            b = ($urandom_range(0, 7) == 0);
            d = 8'($urandom);
            waited = 0;
            do begin
                out_ready = 4'($urandom);
                send(s, b, d, f);
                waited++;
            end while (!f && waited < 50);
            if (!f) begin
                n_total++;
                $error("FAIL accept_timeout: observed=not accepted expected=accepted within 50 cycles");
            end
        end
        in_valid = 1'b0;
        out_ready = 4'hF;
        repeat (4) cycle(f);
        #1 chk("drained", 32'(out_valid), 32'd0);

        // Out-of-range selector on the three-channel instance
        @(negedge clk);
        b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'hEE;
        #1;
        chk("bad_sel_ready", 32'(b_in_ready), 32'd1);
        chk("bad_sel_err_before", 32'(b_err_sel), 32'd0);
        @(negedge clk);
        b_in_data = 8'hEF;
        #1;
        chk("bad_sel_err_pulse", 32'(b_err_sel), 32'd1);
        chk("bad_sel_no_valid", 32'(b_out_valid), 32'd0);
        @(negedge clk);
        b_in_valid = 1'b0;
        #1 chk("bad_sel_err_b2b", 32'(b_err_sel), 32'd1);
        @(negedge clk);
        #1;
        chk("bad_sel_err_clear", 32'(b_err_sel), 32'd0);
        chk("bad_sel_no_valid2", 32'(b_out_valid), 32'd0);
        b_out_ready = 3'b000; b_in_valid = 1'b1; b_in_sel = 2'd2; b_in_data = 8'h5A;
        chk("ch2_ready_3ch", 32'(b_in_ready), 32'd1);
        @(negedge clk);
        b_in_valid = 1'b0;
        #1;
        chk("ch2_valid_3ch", 32'(b_out_valid), 32'b100);
        chk("ch2_data_3ch", 32'(b_out_data[23:16]), 32'h5A);
        chk("ch2_no_err_3ch", 32'(b_err_sel), 32'd0);

        // Reset mid-operation discards buffered words
        rst_n = 1'b0;
        #1;
        chk("midrst_b_valid", 32'(b_out_valid), 32'd0);
        chk("midrst_b_data", 32'(b_out_data), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_stream_demux
`default_nettype wire

// File: doc/stream_demux.md
# stream_demux

Parametrised 1-to-N streaming demultiplexer with valid/ready handshakes, per-channel 2-entry output buffering and a broadcast mode. It routes each accepted input word to the output channel chosen by `in_sel`, or to all channels when `in_bcast` is set. It replaces the combinational 1-to-4 demux wherever the consumers can apply backpressure.

## Interface
Parameters:
- `N_CH`, default 4: number of output channels, 1..16.
- `W`, default 8: data width in bits, ≥1.
- `SEL_W`, default `max(1, clog2(N_CH))`: selector width, derived, not overridden.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input word present.
- `in_ready` output 1: input word accepted this cycle when `in_valid & in_ready`.
- `in_data` input W: input word.
- `in_sel` input SEL_W: target channel index.
- `in_bcast` input 1: write the word to all channels; `in_sel` is ignored.
- `out_valid` output N_CH: per-channel word present.
- `out_ready` input N_CH: per-channel consumer ready.
- `out_data` output N_CH*W: channel k occupies bits [k*W +: W].
- `err_sel` output 1: one-cycle pulse; an out-of-range selector word was dropped.

## Operation
- Each channel has a 2-entry FIFO (`cnt` ∈ {0,1,2}). `out_valid[k] = (cnt_k != 0)`. `out_data` shows the head entry.
- Channel k is non-full when `cnt_k < 2`. Readiness depends only on registered count, so there is no combinational path from `out_ready` to `in_ready`.
- Unicast (`in_bcast=0`, `in_sel < N_CH`): `in_ready` = non-full of channel `in_sel`. On handshake, the word is pushed into that channel only.
- Broadcast (`in_bcast=1`): `in_ready` = AND of non-full over all channels. On handshake, the word is pushed into every channel in the same cycle. There is no partial broadcast.
- Invalid selector (`in_bcast=0`, `in_sel >= N_CH`): `in_ready=1`. The word is dropped and `err_sel` pulses on the next cycle. Channel state is unchanged.
- Pop on channel k when `out_valid[k] & out_ready[k]`.
- Push and pop in the same cycle on one channel: `cnt` is unchanged, the head advances, and order is preserved.
- Pop from `cnt=2` and push in the same cycle is impossible, because push requires `cnt<2`.
- Channels are independent. A stalled channel never blocks unicast traffic to other channels. It does block broadcast.
- When `in_valid=0`, `in_ready` still reflects the current selector and mode (combinational from `in_sel`, `in_bcast` and counts).

## Timing
- Reset (async assert, sync release): all `cnt=0`, `out_valid=0`, `out_data=0`, `err_sel=0`, FIFO pointers 0.
- Latency: a word accepted at edge t appears on `out_valid/out_data` immediately after edge t (one register stage). The earliest pop is at edge t+1.
- Throughput: 1 word/cycle per channel with continuous `out_ready` (`cnt` holds at 1).
- `err_sel` is registered. It is high for exactly the cycle following each dropped word, and back-to-back drops give a continuous high.
- Reset mid-operation: all buffered words are discarded and no partial broadcast survives.
- Inputs must be stable when `in_valid=1 & in_ready=0`. Outputs hold `out_data` stable while `out_valid & !out_ready`.

## Structure
- Package `stream_demux_pkg` holds:
  - the `sel_width(n)` function;
  - `CH_DEPTH = 2`;
  - the `cnt_t` typedef (2 bits).
- Sub-module `demux_chan_buf` is a 2-entry FIFO. Ports: `clk`, `rst_n`, `push`, `push_data`, `full`, `valid`, `ready`, `data`. It is instantiated N_CH times in a generate loop.
- The top level holds the selector decode, the broadcast AND-reduction, the push-enable fan-out and the `err_sel` register.

## Test plan
- Reset with `in_valid=1`: all `out_valid=0`, `out_data=0`, `err_sel=0` during and after reset; `in_ready=1` after release.
- Unicast with N_CH=4, W=8: send 0x11→ch1, 0x22→ch3 with all `out_ready=1`. `out_valid` = 4'b0010 then 4'b1000, with correct data. No other channel asserts.
- Backpressure: `out_ready[2]=0`, send 0xA0, 0xA1, 0xA2 to ch2. The first two are accepted, then `in_ready=0`. Meanwhile 0x55→ch0 is accepted. Release ch2: it pops 0xA0, 0xA1, then accepts 0xA2.
- Broadcast: ch1 full, send 0x7E with `in_bcast=1`. `in_ready=0`, no channel written. Drain ch1 one entry: 0x7E is accepted and appears on all 4 channels in the same cycle.
- Invalid selector with N_CH=3, `in_sel=3`: the handshake completes, `err_sel` is high exactly one cycle later, and no `out_valid` changes.
- Throughput and order: 64 random words to random channels with random `out_ready`. A scoreboard confirms per-channel order, no loss or duplication, and 1 word/cycle when all ready.
